load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, number of BUS-state cycles without bus_ack before the access is aborted; legal range 1..255.
REQ-002 Ports are, in order:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- dmem_read  in  1  load request from control, stage 0.
- dmem_write  in  1  store request from control.
- funct3  in  3  access size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW).
- addr  in  32  effective byte address from the ALU.
- store_data  in  32  rs2 value.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address, bits [1:0] = 0.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated write data.
- bus_rdata  in  32  read data, valid with bus_ack.
- bus_ack  in  1  one-cycle completion.
- load_data  out  32  aligned, extended load result.
- load_valid  out  1  one-cycle pulse when load_data updates.
- stall  out  1  freezes PC and the control stage.
- fault  out  1  one-cycle pulse on a misaligned, illegal, conflicting or timed-out access.

Function
REQ-003 FSM states: IDLE, BUS, DONE.
REQ-004 IDLE, request present (dmem_read or dmem_write) and legal: register addr, funct3, we and store_data; go to BUS next cycle.
REQ-005 Illegal request, detected in IDLE:
- dmem_read and dmem_write both high;
- load funct3 of 3, 6 or 7;
- store funct3 greater than 2;
- halfword with addr[0]=1;
- word with addr[1:0]≠0.
Response: fault pulses the next cycle; no bus access; FSM stays in IDLE.
REQ-006 BUS: bus_req=1. bus_we, bus_addr, bus_be and bus_wdata are driven from registers and stay stable until the cycle bus_ack is sampled high.
REQ-007 bus_be:
- byte access: 1 shifted left by addr[1:0];
- halfword: 0011 when addr[1]=0, 1100 when addr[1]=1;
- word: 1111.
REQ-008 bus_wdata: byte replicated ×4; halfword replicated ×2; word unchanged.
REQ-009 bus_ack in BUS:
- load: select the lane by the registered addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU) into load_data;
- any access: go to DONE.
REQ-010 DONE lasts one cycle: load_valid=1 for loads only; then IDLE. A new request is not accepted in DONE.
REQ-011 load_data holds its value until the next completed load; the control stage-1 writeback reads it.
REQ-012 stall is combinational:
- high when in IDLE with a legal request present;
- high throughout BUS;
- low in DONE and otherwise.
Latency: request cycle -> bus_req next cycle; ack cycle -> DONE next cycle. Minimum 3 cycles for the whole access.
REQ-013 Timeout counter: 8-bit; cleared on entry to BUS; increments each BUS cycle without ack.
- On reaching TIMEOUT_CYCLES: drop bus_req, pulse fault, return to IDLE; load_data is not updated.
- bus_ack in the same cycle the limit is reached: ack wins; no fault.
REQ-014 bus_ack while not in BUS is ignored.
REQ-015 Addresses wrap modulo 2^32; no other address checking.

Reset
REQ-016 reset low drives, asynchronously:
- FSM to IDLE, timeout counter to 0;
- bus_req, bus_we, load_valid, fault to 0;
- bus_be to 0000;
- bus_addr, bus_wdata, load_data to 0.
REQ-017 Reset asserted mid-access: bus_req drops in the same cycle; the access is abandoned with no fault and no load_valid.
REQ-018 Deassertion is synchronised externally; first accept is possible on the first clk edge after deassertion.

Structure
REQ-019 funct3 load/store encodings and FSM state encodings go in the shared include alongside the existing INS_* and FUNCT3_* defines.
REQ-020 Byte-lane extraction/extension is one sub-module, load_align (combinational: rdata, addr[1:0], funct3 -> data); store lane replication stays inline.

Verification
REQ-021 LW addr=0x100, bus_rdata=0xDEADBEEF, ack after 2 BUS cycles -> bus_addr=0x100, bus_be=1111, load_valid 1 cycle after ack, load_data=0xDEADBEEF, stall high 3 cycles.
REQ-022 LB addr=0x103, rdata=0x80FF_FF7F -> bus_be=1000, load_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-023 SH addr=0x202, store_data=0x1234ABCD -> bus_we=1, bus_addr=0x200, bus_be=1100, bus_wdata=0xABCDABCD, no load_valid.
REQ-024 LW addr=0x101, and separately dmem_read=dmem_write=1 -> fault pulse, bus_req never asserted, stall low.
REQ-025 TIMEOUT_CYCLES=4, no ack -> bus_req high exactly 4 cycles, then fault pulse; load_data unchanged. Ack on the 4th cycle -> no fault.
REQ-026 reset low during BUS -> bus_req=0 the same cycle; after release a new LW completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 access codes,
// FSM states and the request legality check.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    function automatic logic req_illegal(
        input logic       rd,
        input logic       wr,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic bad;
        bad = 1'b0;
        if (rd && wr)
            bad = 1'b1;
        if (rd && !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}))
            bad = 1'b1;
        if (wr && !(f3 inside {F3_SB, F3_SH, F3_SW}))
            bad = 1'b1;
        if (f3[1:0] == SZ_H && off[0])
            bad = 1'b1;
        if (f3[1:0] == SZ_W && off != 2'b00)
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load lane extraction: picks the byte/halfword addressed by off
// out of the bus word and sign- or zero-extends it.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sext;

    always_comb begin
        lane_b = rdata[{off, 3'b000} +: 8];
        lane_h = off[1] ? rdata[31:16] : rdata[15:0];
        // funct3[2] marks the unsigned variants
        sext   = !funct3[2];
        unique case (funct3[1:0])
            SZ_B:    data = {{24{sext & lane_b[7]}}, lane_b};
            SZ_H:    data = {{16{sext & lane_h[15]}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one bus access at a time, three-state FSM with
// request legality checks, lane steering and a bus timeout.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        stall,
    output logic        fault
);

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

    lsu_state_e  state_q;
    lsu_state_e  state_d;
    logic [7:0]  cnt_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;

    logic        req;
    logic        illegal;
    logic        accept;
    logic        reject;
    logic        timeout;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] aligned;

    always_comb begin
        req     = dmem_read | dmem_write;
        illegal = req_illegal(dmem_read, dmem_write,
                              funct3, addr[1:0]);
        accept  = (state_q == ST_IDLE) && req && !illegal;
        reject  = (state_q == ST_IDLE) && req && illegal;
        // an ack in the limit cycle still completes the access
        timeout = (state_q == ST_BUS) && !bus_ack &&
                  (cnt_q + 8'd1 == TO_LIM);
    end

    always_comb begin
        be_d    = 4'hF;
        wdata_d = store_data;
        unique case (funct3[1:0])
            SZ_B: begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{store_data[7:0]}};
            end
            SZ_H: begin
                be_d    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{store_data[15:0]}};
            end
            default: begin
                be_d    = 4'hF;
                wdata_d = store_data;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept)
                    state_d = ST_BUS;
            end
            ST_BUS: begin
                if (bus_ack)
                    state_d = ST_DONE;
                else if (timeout)
                    state_d = ST_IDLE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus_req    = (state_q == ST_BUS);
    assign stall      = accept | bus_req;
    assign load_valid = (state_q == ST_DONE) && !bus_we;

    load_align u_align (
        .rdata  (bus_rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (aligned)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= 8'd0;
            off_q     <= 2'd0;
            f3_q      <= 3'd0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            load_data <= 32'd0;
            fault     <= 1'b0;
        end else begin
            fault <= reject | timeout;
            if (accept) begin
                cnt_q     <= 8'd0;
                off_q     <= addr[1:0];
                f3_q      <= funct3;
                bus_we    <= dmem_write;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_be    <= be_d;
                bus_wdata <= wdata_d;
            end
            if (state_q == ST_BUS && !bus_ack)
                cnt_q <= cnt_q + 8'd1;
            if (state_q == ST_BUS && bus_ack && !bus_we)
                load_data <= aligned;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, reset
// and ignored-ack sequences, then random accesses vs a model.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        dmem_read;
    logic        dmem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [31:0] load_data;
    logic        load_valid;
    logic        stall;
    logic        fault;

    int          n_checks;
    int          n_errors;
    logic [31:0] model_ld;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .load_data  (load_data),
        .load_valid (load_valid),
        .stall      (stall),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          ack_at;
        bit          ill;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_illegal(bit rd, bit wr,
                                     logic [2:0] f3,
                                     logic [31:0] a);
        int n;
        if (rd && wr) return 1'b1;
        if (rd && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
        if (wr && f3 > 2) return 1'b1;
        n = 1 << (f3 % 4);
        return (a % n) != 0;
    endfunction

    function automatic logic [3:0] m_be(logic [2:0] f3,
                                        logic [31:0] a);
        int n;
        n = 1 << (f3 % 4);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(logic [2:0] f3,
                                            logic [31:0] sd);
        case (f3 % 4)
            0:       return (sd & 32'hFF) * 32'h01010101;
            1:       return (sd & 32'hFFFF) * 32'h00010001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] f3,
                                           logic [31:0] a,
                                           logic [31:0] rd);
        int          n;
        logic [31:0] v;
        logic [31:0] mask;
        n = 1 << (f3 % 4);
        if (n >= 4) return rd;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = (rd >> (8 * (a % 4))) & mask;
        if (f3 < 4 && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic run_access(input bit rd, input bit wr,
                              input logic [2:0] f3,
                              input logic [31:0] a,
                              input logic [31:0] sd,
                              input logic [31:0] rdata,
                              input int ack_at,
                              input bit ill,
                              input logic [3:0] ebe,
                              input logic [31:0] ewd,
                              input logic [31:0] eld);
        bit acked;
        int k;
        dmem_read  = rd;
        dmem_write = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        @(negedge clk);
        chk("req_stall", stall, !ill);
        chk("req_bus_req", bus_req, 0);
        @(posedge clk); #1;
        dmem_read  = 0;
        dmem_write = 0;
        if (ill) begin
            @(negedge clk);
            chk("ill_fault", fault, 1);
            chk("ill_bus_req", bus_req, 0);
            chk("ill_stall", stall, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("ill_fault_end", fault, 0);
            chk("ill_bus_req2", bus_req, 0);
            @(posedge clk); #1;
            return;
        end
        acked = 0;
        k = 1;
        while (!acked && k <= TO) begin
            bus_ack   = (k == ack_at);
            bus_rdata = bus_ack ? rdata : $urandom;
            @(negedge clk);
            chk("bus_req", bus_req, 1);
            chk("bus_stall", stall, 1);
            chk("bus_addr", bus_addr, a & 32'hFFFFFFFC);
            chk("bus_be", bus_be, ebe);
            chk("bus_we", bus_we, wr);
            if (wr) chk("bus_wdata", bus_wdata, ewd);
            chk("bus_fault", fault, 0);
            chk("bus_lvalid", load_valid, 0);
            acked = bus_ack;
            @(posedge clk); #1;
            bus_ack = 0;
            k++;
        end
        @(negedge clk);
        chk("end_bus_req", bus_req, 0);
        chk("end_stall", stall, 0);
        if (acked) begin
            chk("done_fault", fault, 0);
            chk("done_lvalid", load_valid, rd);
            if (rd) model_ld = eld;
        end else begin
            chk("timeout_fault", fault, 1);
            chk("timeout_lvalid", load_valid, 0);
        end
        chk("load_data", load_data, model_ld);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_fault", fault, 0);
        chk("post_lvalid", load_valid, 0);
        chk("post_bus_req", bus_req, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0] ld_f3[5];
        n_checks   = 0;
        n_errors   = 0;
        model_ld   = 32'd0;
        reset      = 1'b0;
        dmem_read  = 0;
        dmem_write = 0;
        funct3     = 3'd0;
        addr       = 32'd0;
        store_data = 32'd0;
        bus_rdata  = 32'd0;
        bus_ack    = 1'b0;
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        tbl[0]  = '{1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 2,
                    0, 4'hF, 32'h0, 32'hDEADBEEF};
        tbl[1]  = '{1, 0, 3'd0, 32'h103, 32'h0, 32'h80FFFF7F, 1,
                    0, 4'h8, 32'h0, 32'hFFFFFF80};
        tbl[2]  = '{1, 0, 3'd4, 32'h103, 32'h0, 32'h80FFFF7F, 3,
                    0, 4'h8, 32'h0, 32'h00000080};
        tbl[3]  = '{0, 1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, 1,
                    0, 4'hC, 32'hABCDABCD, 32'h0};
        tbl[4]  = '{1, 0, 3'd2, 32'h101, 32'h0, 32'h0, 1,
                    1, 4'h0, 32'h0, 32'h0};
        tbl[5]  = '{1, 1, 3'd2, 32'h100, 32'h0, 32'h0, 1,
                    1, 4'h0, 32'h0, 32'h0};
        tbl[6]  = '{1, 0, 3'd2, 32'h300, 32'h0, 32'h55555555, 0,
                    0, 4'hF, 32'h0, 32'h0};
        tbl[7]  = '{1, 0, 3'd2, 32'h304, 32'h0, 32'h11223344, 4,
                    0, 4'hF, 32'h0, 32'h11223344};
        tbl[8]  = '{1, 0, 3'd1, 32'h102, 32'h0, 32'h80011234, 1,
                    0, 4'hC, 32'h0, 32'hFFFF8001};
        tbl[9]  = '{1, 0, 3'd5, 32'h102, 32'h0, 32'h80011234, 2,
                    0, 4'hC, 32'h0, 32'h00008001};
        tbl[10] = '{1, 0, 3'd3, 32'h0, 32'h0, 32'h0, 1,
                    1, 4'h0, 32'h0, 32'h0};
        tbl[11] = '{0, 1, 3'd4, 32'h0, 32'h0, 32'h0, 1,
                    1, 4'h0, 32'h0, 32'h0};
        tbl[12] = '{0, 1, 3'd0, 32'h7, 32'h000000A5, 32'h0, 2,
                    0, 4'h8, 32'hA5A5A5A5, 32'h0};
        tbl[13] = '{0, 1, 3'd2, 32'hFFFFFFFC, 32'hCAFEF00D, 32'h0, 1,
                    0, 4'hF, 32'hCAFEF00D, 32'h0};
        tbl[14] = '{1, 0, 3'd0, 32'h1, 32'h0, 32'h00007F00, 1,
                    0, 4'h2, 32'h0, 32'h0000007F};
        tbl[15] = '{1, 0, 3'd1, 32'h3, 32'h0, 32'h0, 1,
                    1, 4'h0, 32'h0, 32'h0};
        tbl[16] = '{0, 1, 3'd1, 32'h1, 32'h0, 32'h0, 1,
                    1, 4'h0, 32'h0, 32'h0};
        tbl[17] = '{0, 1, 3'd2, 32'h2, 32'h0, 32'h0, 1,
                    1, 4'h0, 32'h0, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_lvalid", load_valid, 0);
        chk("rst_fault", fault, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i])
            run_access(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a,
                       tbl[i].sd, tbl[i].rdata, tbl[i].ack_at,
                       tbl[i].ill, tbl[i].be, tbl[i].wd, tbl[i].ld);

        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("idle_ack_bus_req", bus_req, 0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_lvalid", load_valid, 0);
        chk("idle_ack_fault", fault, 0);
        chk("idle_ack_ld", load_data, model_ld);
        @(posedge clk); #1;

        dmem_read = 1;
        funct3    = 3'd2;
        addr      = 32'h400;
        @(posedge clk); #1;
        dmem_read = 0;
        @(negedge clk);
        chk("mid_bus_req", bus_req, 1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_bus_req", bus_req, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_addr", bus_addr, 0);
        @(posedge clk); #1;
        bus_ack = 1'b1;
        @(negedge clk);
        chk("mid_rst_fault", fault, 0);
        chk("mid_rst_lvalid", load_valid, 0);
        bus_ack = 1'b0;
        reset   = 1'b1;
        model_ld = 32'd0;
        @(posedge clk); #1;
        chk("mid_rst_ld", load_data, 0);
        chk("mid_rst_bus_req2", bus_req, 0);
        run_access(1, 0, 3'd2, 32'h500, 32'h0, 32'h0BADF00D, 1,
                   0, 4'hF, 32'h0, 32'h0BADF00D);

        for (int i = 0; i < 200; i++) begin
            int          r;
            bit          rd;
            bit          wr;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] sd;
            logic [31:0] rdt;
            bit          ill;
            r  = $urandom_range(0, 99);
            rd = (r < 47) || (r >= 94);
            wr = (r >= 47);
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0)
                f3 = rd ? ld_f3[$urandom_range(0, 4)]
                        : 3'($urandom_range(0, 2));
            a   = $urandom;
            if ($urandom_range(0, 1) == 1)
                a = a & ~(32'((1 << (f3 % 4)) - 1));
            sd  = $urandom;
            rdt = $urandom;
            ill = m_illegal(rd, wr, f3, a);
            run_access(rd, wr, f3, a, sd, rdt,
                       $urandom_range(0, TO), ill,
                       m_be(f3, a), m_wdata(f3, sd),
                       m_load(f3, a, rdt));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
